// File: rtl/kms_bridge.sv
// Keyboard/mouse byte-stream bridge from the SPI_CLK domain into the system clock domain.
// Define KMS_KBD_FIFO_EN for a 2**KBD_FIFO_AW entry keyboard FIFO; otherwise a single holding register.
module kms_bridge #(
    parameter int KBD_FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kms_level,
    input  logic [1:0] kms_type,
    input  logic [7:0] kms_data,
    input  logic [2:0] mouse_buttons_in,
    output logic [7:0] mouse_x,
    output logic [7:0] mouse_y,
    output logic [2:0] mouse_btn,
    output logic [7:0] kbd_data,
    output logic       kbd_valid,
    input  logic       kbd_ready,
    output logic       kbd_ovf,
    input  logic       kbd_ovf_clr,
    output logic [7:0] osd_data,
    output logic       osd_strobe
);

    logic       level_s1;
    logic       level_s2;
    logic       level_prev;
    logic [1:0] arm_cnt;
    logic       arm;
    logic       kms_event;
    logic [2:0] btn_s1;
    logic       kbd_push;
    logic       kbd_pop;
    logic       kbd_drop;

    // arm holds off events until the level history has settled, so an upstream
    // toggle that was never reset cannot fire a spurious event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_s1   <= 1'b0;
            level_s2   <= 1'b0;
            level_prev <= 1'b0;
            arm_cnt    <= 2'd0;
            arm        <= 1'b0;
        end else begin
            level_s1   <= kms_level;
            level_s2   <= level_s1;
            level_prev <= level_s2;
            if (!arm) begin
                if (arm_cnt == 2'd2) begin
                    arm <= 1'b1;
                end else begin
                    arm_cnt <= arm_cnt + 2'd1;
                end
            end
        end
    end

    assign kms_event = arm & (level_s2 ^ level_prev);
    assign kbd_push  = kms_event & (kms_type == 2'd2);
    assign kbd_pop   = kbd_valid & kbd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mouse_x    <= 8'h00;
            mouse_y    <= 8'h00;
            osd_data   <= 8'h00;
            osd_strobe <= 1'b0;
            btn_s1     <= 3'b000;
            mouse_btn  <= 3'b000;
        end else begin
            btn_s1     <= mouse_buttons_in;
            mouse_btn  <= btn_s1;
            osd_strobe <= kms_event & (kms_type == 2'd3);
            if (kms_event && kms_type == 2'd0) begin
                mouse_x <= mouse_x + kms_data;
            end
            if (kms_event && kms_type == 2'd1) begin
                mouse_y <= mouse_y + kms_data;
            end
            if (kms_event && kms_type == 2'd3) begin
                osd_data <= kms_data;
            end
        end
    end

`ifdef KMS_KBD_FIFO_EN
    localparam int DEPTH = 1 << KBD_FIFO_AW;

    logic [7:0]             kbd_mem [DEPTH];
    logic [KBD_FIFO_AW-1:0] wr_ptr;
    logic [KBD_FIFO_AW-1:0] rd_ptr;
    logic [KBD_FIFO_AW:0]   kbd_count;
    logic                   kbd_full;
    logic                   kbd_accept;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign kbd_full   = (kbd_count == (KBD_FIFO_AW + 1)'(DEPTH));
    assign kbd_accept = kbd_push & (~kbd_full | kbd_pop);
    assign kbd_drop   = kbd_push & kbd_full & ~kbd_pop;
    assign kbd_valid  = (kbd_count != '0);
    assign kbd_data   = kbd_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            kbd_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                kbd_mem[i] <= 8'h00;
            end
        end else begin
            if (kbd_accept) begin
                kbd_mem[wr_ptr] <= kms_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (kbd_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({kbd_accept, kbd_pop})
                2'b10:   kbd_count <= kbd_count + 1'b1;
                2'b01:   kbd_count <= kbd_count - 1'b1;
                default: kbd_count <= kbd_count;
            endcase
        end
    end
`else
    logic [7:0] hold_data;
    logic       hold_valid;

    assign kbd_drop  = kbd_push & hold_valid & ~kbd_pop;
    assign kbd_valid = hold_valid;
    assign kbd_data  = hold_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= 8'h00;
            hold_valid <= 1'b0;
        end else if (kbd_push && (!hold_valid || kbd_pop)) begin
            hold_data  <= kms_data;
            hold_valid <= 1'b1;
        end else if (kbd_pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // Overflow is sticky; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbd_ovf <= 1'b0;
        end else if (kbd_drop) begin
            kbd_ovf <= 1'b1;
        end else if (kbd_ovf_clr) begin
            kbd_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kms_bridge.sv
// Randomised scoreboard bench for kms_bridge: stimulus schedules expected effects,
// a monitor retires them against a queue-based model after every clock edge.
module tb_kms_bridge;

`ifdef KMS_KBD_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       kms_level = 1'b1;
    logic [1:0] kms_type = 2'd0;
    logic [7:0] kms_data = 8'h00;
    logic [2:0] mouse_buttons_in = 3'b000;
    logic       kbd_ready = 1'b0;
    logic       kbd_ovf_clr = 1'b0;
    logic [7:0] mouse_x;
    logic [7:0] mouse_y;
    logic [2:0] mouse_btn;
    logic [7:0] kbd_data;
    logic       kbd_valid;
    logic       kbd_ovf;
    logic [7:0] osd_data;
    logic       osd_strobe;

    kms_bridge dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .kms_level        (kms_level),
        .kms_type         (kms_type),
        .kms_data         (kms_data),
        .mouse_buttons_in (mouse_buttons_in),
        .mouse_x          (mouse_x),
        .mouse_y          (mouse_y),
        .mouse_btn        (mouse_btn),
        .kbd_data         (kbd_data),
        .kbd_valid        (kbd_valid),
        .kbd_ready        (kbd_ready),
        .kbd_ovf          (kbd_ovf),
        .kbd_ovf_clr      (kbd_ovf_clr),
        .osd_data         (osd_data),
        .osd_strobe       (osd_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    ev_t        sched[$];
    logic [7:0] exp_kbd[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_x = 8'h00;
    logic [7:0] exp_y = 8'h00;
    logic [7:0] exp_osd = 8'h00;
    logic       exp_strobe = 1'b0;
    logic       exp_ovf = 1'b0;
    logic [2:0] exp_btn = 3'b000;
    logic [2:0] btn_hist = 3'b000;
    logic       rand_mode = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: advance the model by one edge, then compare every output.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (!rst_n) begin
                sched.delete();
                exp_kbd.delete();
                exp_x = 8'h00; exp_y = 8'h00; exp_osd = 8'h00;
                exp_strobe = 1'b0; exp_ovf = 1'b0; exp_btn = 3'b000; btn_hist = 3'b000;
            end else begin
                logic dropped;
                dropped = 1'b0;
                if (exp_kbd.size() > 0 && kbd_ready) begin
                    void'(exp_kbd.pop_front());
                end
                exp_strobe = 1'b0;
                while (sched.size() > 0 && sched[0].due <= cyc) begin
                    ev_t ev;
                    ev = sched.pop_front();
                    case (ev.kind)
                        2'd0: exp_x = 8'((int'(exp_x) + int'(ev.data)) % 256);
                        2'd1: exp_y = 8'((int'(exp_y) + int'(ev.data)) % 256);
                        2'd2: begin
                            if (exp_kbd.size() < DEPTH) exp_kbd.push_back(ev.data);
                            else dropped = 1'b1;
                        end
                        default: begin
                            exp_strobe = 1'b1;
                            exp_osd    = ev.data;
                        end
                    endcase
                end
                if (dropped) exp_ovf = 1'b1;
                else if (kbd_ovf_clr) exp_ovf = 1'b0;
                exp_btn  = btn_hist;
                btn_hist = mouse_buttons_in;
            end
            check_output("mouse_x", 32'(mouse_x), 32'(exp_x));
            check_output("mouse_y", 32'(mouse_y), 32'(exp_y));
            check_output("mouse_btn", 32'(mouse_btn), 32'(exp_btn));
            check_output("osd_strobe", 32'(osd_strobe), 32'(exp_strobe));
            check_output("osd_data", 32'(osd_data), 32'(exp_osd));
            check_output("kbd_ovf", 32'(kbd_ovf), 32'(exp_ovf));
            check_output("kbd_valid", 32'(kbd_valid), 32'(exp_kbd.size() > 0));
            if (exp_kbd.size() > 0) check_output("kbd_data", 32'(kbd_data), 32'(exp_kbd[0]));
            else if (!rst_n) check_output("kbd_data_rst", 32'(kbd_data), 32'h0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rand_mode) begin
                kbd_ready   = 1'($urandom_range(0, 1));
                kbd_ovf_clr = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 15) == 0) mouse_buttons_in = 3'($urandom_range(0, 7));
            end
        end
    endtask

    task automatic toggle(input logic [1:0] kind, input logic [7:0] data);
        @(negedge clk);
        kms_level = ~kms_level;
        kms_type  = kind;
        kms_data  = data;
        sched.push_back('{due: cyc + 3, kind: kind, data: data});
    endtask

    task automatic apply_stimulus(input logic [1:0] kind, input logic [7:0] data, input int gap);
        toggle(kind, data);
        tick(gap);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        mouse_buttons_in = 3'b101;
        tick(4);
        // Release with kms_level already high: nothing may happen.
        @(negedge clk) rst_n = 1'b1;
        tick(10);

        apply_stimulus(2'd0, 8'h05, 5);
        apply_stimulus(2'd1, 8'hFE, 5);
        apply_stimulus(2'd0, 8'hF7, 5);
        apply_stimulus(2'd0, 8'h08, 5);
        apply_stimulus(2'd0, 8'hFC, 5);
        apply_stimulus(2'd0, 8'h80, 5);

        kbd_ready = 1'b0;
        for (int i = 0; i < 9; i++) apply_stimulus(2'd2, 8'(8'h10 + i), 4);
        @(negedge clk) kbd_ready = 1'b1;
        tick(12);
        @(negedge clk) kbd_ready = 1'b0; kbd_ovf_clr = 1'b1;
        @(negedge clk) kbd_ovf_clr = 1'b0;

        // Full plus a push landing on the same edge as a pop.
        for (int i = 0; i < DEPTH; i++) apply_stimulus(2'd2, 8'(8'h30 + i), 4);
        toggle(2'd2, 8'h20);
        @(negedge clk);
        @(negedge clk) kbd_ready = 1'b1;
        @(negedge clk) kbd_ready = 1'b0;
        tick(3);
        @(negedge clk) kbd_ready = 1'b1;
        tick(12);
        @(negedge clk) kbd_ready = 1'b0;

        apply_stimulus(2'd3, 8'h45, 6);

        rand_mode = 1'b1;
        repeat (60) apply_stimulus(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), $urandom_range(4, 8));
        rand_mode = 1'b0;
        kbd_ovf_clr = 1'b0;

        // Reset in the middle of a burst, with a toggle in flight.
        kbd_ready = 1'b0;
        apply_stimulus(2'd2, 8'hA1, 4);
        apply_stimulus(2'd0, 8'h11, 4);
        toggle(2'd1, 8'h22);
        @(negedge clk) rst_n = 1'b0;
        tick(3);
        @(negedge clk) rst_n = 1'b1;
        tick(6);
        apply_stimulus(2'd0, 8'h7F, 5);
        apply_stimulus(2'd2, 8'h5A, 5);
        apply_stimulus(2'd3, 8'h99, 5);
        @(negedge clk) kbd_ready = 1'b1;
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/kms_bridge.md
# kms_bridge

Consumes the keyboard/mouse byte stream that the SPI user-IO stage produces in the SPI_CLK domain and converts it into system-clock-domain state for the Amiga side. Mouse movement bytes are accumulated into wrapping 8-bit horizontal and vertical counters, in JOY0DAT style. Mouse buttons are synchronised. Amiga keycodes are queued in a first-word-fall-through FIFO with a valid/ready handshake. OSD keycodes are emitted as single-cycle strobes.

## Interface
Parameters:
- KBD_FIFO_AW, default 3: log2 of the keyboard FIFO depth, giving 8 entries. Used only when KMS_KBD_FIFO_EN is defined.

Ports:
- clk  in  1  system clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- kms_level  in  1  toggles once per received kbd/mouse byte. SPI_CLK domain.
- kms_type  in  2  0=mouse X, 1=mouse Y, 2=Amiga keycode, 3=OSD keycode. SPI_CLK domain.
- kms_data  in  8  payload byte. SPI_CLK domain.
- mouse_buttons_in  in  3  raw button state. SPI_CLK domain, quasi-static.
- mouse_x  out  8  horizontal counter.
- mouse_y  out  8  vertical counter.
- mouse_btn  out  3  synchronised buttons.
- kbd_data  out  8  FIFO head.
- kbd_valid  out  1  FIFO non-empty.
- kbd_ready  in  1  consumer accepts head.
- kbd_ovf  out  1  sticky overflow flag.
- kbd_ovf_clr  in  1  clears kbd_ovf.
- osd_data  out  8  OSD keycode.
- osd_strobe  out  1  one-cycle pulse, osd_data valid.

## Operation
- kms_level passes through a 2-flop synchroniser (s1, s2), then a history flop (prev).
  - event = s2 XOR prev, qualified by arm.
- arm clears on reset and sets on the 3rd clk edge after rst_n deasserts. This suppresses the spurious event from an unreset upstream toggle.
- On event, kms_type and kms_data are sampled directly. They are stable because upstream holds them ≥8 SPI_CLK periods after the toggle.
- Actions by type:
  - type 0: mouse_x <= mouse_x + kms_data, treated as two's-complement, modulo 256.
  - type 1: mouse_y <= mouse_y + kms_data, same rule.
  - type 2: push kms_data into the keyboard FIFO.
  - type 3: osd_data <= kms_data; osd_strobe = 1 for exactly one cycle.
- mouse_buttons_in: each bit is 2-flop synchronised to mouse_btn. No event qualification.
- Keyboard FIFO rules:
  - First-word-fall-through; kbd_data always equals the head entry.
  - pop = kbd_valid & kbd_ready.
  - Push while full and no pop: byte dropped, kbd_ovf <= 1.
  - Push while full with pop in the same cycle: both happen, no overflow.
  - Push while empty: kbd_valid rises on the following cycle.
  - kbd_ovf clears on kbd_ovf_clr. If set and clear coincide, set wins.
- Reset values: mouse_x=0, mouse_y=0, mouse_btn=0, kbd_valid=0, kbd_data=0, kbd_ovf=0, osd_data=0, osd_strobe=0. FIFO pointers=0.
- Reset mid-operation empties the FIFO and zeroes the counters. An in-flight toggle is discarded.

## Timing
- A kms_level toggle is captured by s1 at edge E0 and by s2 at E1. event is true between E1 and E2.
  - Counter, FIFO and osd changes are visible after E2: 3-edge latency.
- osd_strobe is high for the single cycle following E2.
- Two consecutive toggles must be ≥4 clk periods apart. This is guaranteed when the SPI_CLK period is ≥ clk period / 2 × 8 bits.
- FIFO pop takes effect at the clk edge where kbd_valid & kbd_ready.
  - The next head appears the same cycle the edge completes.
  - kbd_valid falls after popping the last entry.
- mouse_btn latency: 2 edges.

## Configuration
- KMS_KBD_FIFO_EN defined: keyboard FIFO of 2**KBD_FIFO_AW entries, as described above.
- KMS_KBD_FIFO_EN undefined: single holding register, depth 1.
  - kbd_valid is set on push and cleared on pop.
  - Push while valid and not popping: byte dropped, kbd_ovf set.
  - Push with simultaneous pop loads the new byte and keeps kbd_valid=1.
  - KBD_FIFO_AW is ignored.

## Test plan
- Reset release with kms_level already high: no event, no counter change, no osd_strobe, kbd_valid stays 0 for 10 cycles.
- Mouse X then Y: toggles with type 0 data 0x05, then type 1 data 0xFE. Expect mouse_x=0x05 and mouse_y=0xFE, each 3 edges after its toggle.
- X wrap: mouse_x=0xFC, event type 0 data 0x08 -> mouse_x=0x04. Event data 0x80 from 0x00 -> 0x80.
- Keyboard FIFO (KMS_KBD_FIFO_EN, AW=3), kbd_ready=0:
  - Push 9 keycodes 0x10..0x18 -> 8 stored, 0x18 dropped, kbd_ovf=1.
  - Raise kbd_ready -> 0x10..0x17 drained in order; kbd_valid falls after 0x17.
- Full FIFO with push and pop in the same cycle: 0x20 accepted, kbd_ovf stays 0, count stays 8. Without the macro: the holding register takes 0x20 and kbd_valid stays 1.
- OSD key: event type 3 data 0x45 -> osd_strobe high for exactly 1 cycle with osd_data=0x45; FIFO unchanged. Asserting rst_n low mid-burst clears all outputs to their reset values.
